// File: rtl/axi_st_patgen_pkg.sv
// Shared types and constants for the half2full loopback AXI-ST pattern generator.
package axi_st_patgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam logic [1:0] SEL_LFSR  = 2'b00;
    localparam logic [1:0] SEL_INC   = 2'b01;
    localparam logic [1:0] SEL_WALK  = 2'b10;
    localparam logic [1:0] SEL_FIXED = 2'b11;

    localparam int WORD_W  = 80;
    localparam int LFSR_W  = 40;
    localparam int TDATA_W = 512;

    localparam int TAP_A = 40;
    localparam int TAP_B = 38;
    localparam int TAP_C = 21;
    localparam int TAP_D = 19;

    localparam logic [WORD_W-1:0] FIXED_WORD = 80'hAA55_AA55_AA55_AA55_AA55;

    // Fibonacci form: shift toward the MSB, feedback enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A-1] ^ s[TAP_B-1] ^ s[TAP_C-1] ^ s[TAP_D-1]};
    endfunction

endpackage

// File: rtl/axi_st_patgen_word.sv
// Pattern word generator: presents w[k] for the current index and advances on load.
module axi_st_patgen_word
    import axi_st_patgen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 40'h00_0000_0001
) (
    input  logic              wrclk,
    input  logic              rst,
    input  logic [1:0]        sel,
    input  logic              load,
    input  logic              restart,
    output logic [WORD_W-1:0] word,
    output logic [LFSR_W-1:0] k
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 40'h00_0000_0001 : SEED;
    localparam logic [WORD_W-1:0] ONE_W    = 80'd1;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_cur;
    logic [LFSR_W-1:0] k_q, k_d, k_cur;
    logic [6:0]        widx_q, widx_d, widx_cur;

    // Restart takes effect combinationally so the start cycle can already load w[0].
    always_comb begin
        lfsr_cur = restart ? SEED_EFF : lfsr_q;
        k_cur    = restart ? '0 : k_q;
        widx_cur = restart ? '0 : widx_q;

        word = FIXED_WORD;
        case (sel)
            SEL_LFSR:  word = {~lfsr_cur, lfsr_cur};
            SEL_INC:   word = {~k_cur, k_cur};
            SEL_WALK:  word = ONE_W << widx_cur;
            default:   word = FIXED_WORD;
        endcase

        lfsr_d = lfsr_cur;
        k_d    = k_cur;
        widx_d = widx_cur;
        if (load) begin
            lfsr_d = lfsr_step(lfsr_cur);
            k_d    = k_cur + 40'd1;
            widx_d = (widx_cur == 7'd79) ? 7'd0 : widx_cur + 7'd1;
        end
    end

    assign k = k_cur;

    always_ff @(posedge wrclk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
            k_q    <= '0;
            widx_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            k_q    <= k_d;
            widx_q <= widx_d;
        end
    end

endmodule

// File: rtl/axi_st_patgen_h2f_top.sv
// AXI-ST pattern generator: pushes each seed word to the checker FIFO and sends
// the same word, expanded to 512 bits, as an AXI-ST beat.
module axi_st_patgen_h2f_top
    import axi_st_patgen_pkg::*;
#(
    parameter int              PATGEN_MODE    = 1,
    parameter int              AXIST_NUM_CHNL = 7,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 40'h00_0000_0001
) (
    input  logic                            wrclk,
    input  logic                            rst,
    input  logic                            patgen_en,
    input  logic                            cntuspatt_en,
    input  logic [8:0]                      patgen_cnt,
    input  logic [1:0]                      patgen_sel,
    input  logic                            chkr_fifo_full,
    output logic [PATGEN_MODE*WORD_W-1:0]   patgen_din,
    output logic                            patgen_din_wr,
    output logic                            axist_tvalid,
    output logic [TDATA_W-1:0]              axist_tdata,
    input  logic                            axist_tready,
    output logic                            patgen_busy,
    output logic                            patgen_done,
    output logic [8:0]                      patgen_word_cnt
);

    state_e state_q, state_d;
    logic   patgen_en_q, cntuspatt_en_q;
    logic   cont_q, cont_d;
    logic   stop_q, stop_d;
    logic [8:0] cnt_q, cnt_d;
    logic [8:0] word_cnt_q, word_cnt_d;
    logic [PATGEN_MODE*WORD_W-1:0] din_q, din_d;
    logic   din_wr_q, din_wr_d;
    logic [TDATA_W-1:0] tdata_q, tdata_d;
    logic   tvalid_q, tvalid_d;

    logic              gen_load, gen_restart;
    logic [WORD_W-1:0] gen_word;
    logic [LFSR_W-1:0] gen_k;
    logic [TDATA_W-1:0] exp_w;
    logic              start_cnt, start_cont, try_load, last_beat;

    axi_st_patgen_word #(
        .SEED (LFSR_SEED)
    ) u_word (
        .wrclk   (wrclk),
        .rst     (rst),
        .sel     (patgen_sel),
        .load    (gen_load),
        .restart (gen_restart),
        .word    (gen_word),
        .k       (gen_k)
    );

    // Low 40 bits fan out to the lower half, high 40 bits to the upper half.
    always_comb begin
        exp_w = '0;
        for (int i = 0; i < AXIST_NUM_CHNL - 1; i++) begin
            exp_w[40*i +: 40]       = gen_word[39:0];
            exp_w[256 + 40*i +: 40] = gen_word[79:40];
        end
        exp_w[255:240] = gen_word[15:0];
        exp_w[511:496] = gen_word[55:40];
    end

    assign start_cnt  = patgen_en & ~patgen_en_q;
    assign start_cont = cntuspatt_en & ~cntuspatt_en_q;
    assign last_beat  = cont_q ? (stop_q | ~cntuspatt_en)
                               : ((word_cnt_q + 9'd1) == cnt_q);

    always_comb begin
        state_d     = state_q;
        cont_d      = cont_q;
        stop_d      = stop_q;
        cnt_d       = cnt_q;
        word_cnt_d  = word_cnt_q;
        din_d       = din_q;
        din_wr_d    = 1'b0;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        gen_load    = 1'b0;
        gen_restart = 1'b0;
        try_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_cnt || start_cont) begin
                    gen_restart = 1'b1;
                    word_cnt_d  = '0;
                    cnt_d       = patgen_cnt;
                    cont_d      = start_cont;
                    stop_d      = 1'b0;
                    if (!start_cont && patgen_cnt == 9'd0) state_d = ST_DONE;
                    else                                   try_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cont_q && (stop_q || !cntuspatt_en)) state_d = ST_DONE;
                else                                     try_load = 1'b1;
            end
            ST_SEND: begin
                if (axist_tready) begin
                    word_cnt_d = word_cnt_q + 9'd1;
                    tvalid_d   = 1'b0;
                    if (last_beat) state_d = ST_DONE;
                    else           try_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // FIFO full only gates new loads; a presented beat is never withdrawn.
        if (try_load) begin
            if (!chkr_fifo_full) begin
                gen_load = 1'b1;
                din_d    = gen_word;
                din_wr_d = 1'b1;
                tdata_d  = exp_w;
                tvalid_d = 1'b1;
                state_d  = ST_SEND;
            end else begin
                tvalid_d = 1'b0;
                state_d  = ST_WAIT;
            end
        end

        if (state_q != ST_IDLE && cont_q && !cntuspatt_en) stop_d = 1'b1;
    end

    always_ff @(posedge wrclk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            patgen_en_q    <= 1'b0;
            cntuspatt_en_q <= 1'b0;
            cont_q         <= 1'b0;
            stop_q         <= 1'b0;
            cnt_q          <= '0;
            word_cnt_q     <= '0;
            din_q          <= '0;
            din_wr_q       <= 1'b0;
            tdata_q        <= '0;
            tvalid_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            patgen_en_q    <= patgen_en;
            cntuspatt_en_q <= cntuspatt_en;
            cont_q         <= cont_d;
            stop_q         <= stop_d;
            cnt_q          <= cnt_d;
            word_cnt_q     <= word_cnt_d;
            din_q          <= din_d;
            din_wr_q       <= din_wr_d;
            tdata_q        <= tdata_d;
            tvalid_q       <= tvalid_d;
        end
    end

    assign patgen_din      = din_q;
    assign patgen_din_wr   = din_wr_q;
    assign axist_tvalid    = tvalid_q;
    assign axist_tdata     = tdata_q;
    assign patgen_busy     = (state_q != ST_IDLE);
    assign patgen_done     = (state_q == ST_DONE);
    assign patgen_word_cnt = word_cnt_q;

endmodule

// File: tb/tb_axi_st_patgen_h2f_top.sv
// Directed bench for the AXI-ST pattern generator: vector table plus hand sequences.
module tb_axi_st_patgen_h2f_top;

    logic         wrclk = 1'b0;
    logic         rst;
    logic         patgen_en, cntuspatt_en;
    logic [8:0]   patgen_cnt;
    logic [1:0]   patgen_sel;
    logic         chkr_fifo_full;
    logic [79:0]  patgen_din;
    logic         patgen_din_wr;
    logic         axist_tvalid;
    logic [511:0] axist_tdata;
    logic         axist_tready;
    logic         patgen_busy, patgen_done;
    logic [8:0]   patgen_word_cnt;

    always #5 wrclk = ~wrclk;

    axi_st_patgen_h2f_top dut (
        .wrclk           (wrclk),
        .rst             (rst),
        .patgen_en       (patgen_en),
        .cntuspatt_en    (cntuspatt_en),
        .patgen_cnt      (patgen_cnt),
        .patgen_sel      (patgen_sel),
        .chkr_fifo_full  (chkr_fifo_full),
        .patgen_din      (patgen_din),
        .patgen_din_wr   (patgen_din_wr),
        .axist_tvalid    (axist_tvalid),
        .axist_tdata     (axist_tdata),
        .axist_tready    (axist_tready),
        .patgen_busy     (patgen_busy),
        .patgen_done     (patgen_done),
        .patgen_word_cnt (patgen_word_cnt)
    );

    int checks = 0;
    int errors = 0;
    int inv_bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] bexp(input logic [79:0] w);
        logic [511:0] t;
        t = '0;
        for (int i = 0; i < 6; i++) begin
            t[40*i +: 40]       = w[39:0];
            t[256 + 40*i +: 40] = w[79:40];
        end
        t[255:240] = w[15:0];
        t[511:496] = w[55:40];
        return t;
    endfunction

    typedef struct {
        logic       en, cen;
        logic [8:0] cnt;
        logic [1:0] sel;
        logic       full, rdy;
        logic       tv, wr, busy, done;
        logic [79:0] din;
        logic [8:0] wcnt;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic cen, input logic [8:0] cnt,
                                input logic [1:0] sel, input logic full, input logic rdy,
                                input logic tv, input logic wr, input logic busy,
                                input logic done, input logic [79:0] din, input logic [8:0] wcnt);
        vec_t v;
        v.en = en; v.cen = cen; v.cnt = cnt; v.sel = sel; v.full = full; v.rdy = rdy;
        v.tv = tv; v.wr = wr; v.busy = busy; v.done = done; v.din = din; v.wcnt = wcnt;
        return v;
    endfunction

    // A push without its beat is never allowed.
    always @(negedge wrclk) if (!rst && patgen_din_wr && !axist_tvalid) inv_bad++;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[$];
        logic [79:0] l0, l1, l2, l3, i0, i1, i2, fx, one80, wexp;
        int pushes, bad;

        l0 = {40'hFF_FFFF_FFFE, 40'h00_0000_0001};
        l1 = {40'hFF_FFFF_FFFD, 40'h00_0000_0002};
        l2 = {40'hFF_FFFF_FFFB, 40'h00_0000_0004};
        l3 = {40'hFF_FFFF_FFF7, 40'h00_0000_0008};
        i0 = {40'hFF_FFFF_FFFF, 40'h00_0000_0000};
        i1 = {40'hFF_FFFF_FFFE, 40'h00_0000_0001};
        i2 = {40'hFF_FFFF_FFFD, 40'h00_0000_0002};
        fx = 80'hAA55_AA55_AA55_AA55_AA55;
        one80 = 80'd1;

        //              en cen cnt sel full rdy | tv wr busy done din wcnt
        // LFSR, counted 4, back-to-back
        vt.push_back(mk(1, 0, 4, 0, 0, 1, 1, 1, 1, 0, l0, 0));
        vt.push_back(mk(1, 0, 4, 0, 0, 1, 1, 1, 1, 0, l1, 1));
        vt.push_back(mk(1, 0, 4, 0, 0, 1, 1, 1, 1, 0, l2, 2));
        vt.push_back(mk(1, 0, 4, 0, 0, 1, 1, 1, 1, 0, l3, 3));
        vt.push_back(mk(1, 0, 4, 0, 0, 1, 0, 0, 1, 1, l3, 4));
        vt.push_back(mk(0, 0, 4, 0, 0, 1, 0, 0, 0, 0, l3, 4));
        // Increment, counted 3, beat 1 stalled 3 cycles
        vt.push_back(mk(1, 0, 3, 1, 0, 0, 1, 1, 1, 0, i0, 0));
        vt.push_back(mk(1, 0, 3, 1, 0, 1, 1, 1, 1, 0, i1, 1));
        vt.push_back(mk(1, 0, 3, 1, 0, 0, 1, 0, 1, 0, i1, 1));
        vt.push_back(mk(1, 0, 3, 1, 0, 0, 1, 0, 1, 0, i1, 1));
        vt.push_back(mk(1, 0, 3, 1, 0, 0, 1, 0, 1, 0, i1, 1));
        vt.push_back(mk(1, 0, 3, 1, 0, 1, 1, 1, 1, 0, i2, 2));
        vt.push_back(mk(1, 0, 3, 1, 0, 1, 0, 0, 1, 1, i2, 3));
        vt.push_back(mk(0, 0, 3, 1, 0, 1, 0, 0, 0, 0, i2, 3));
        // Fixed, counted 1, FIFO full for 5 cycles at start
        for (int j = 0; j < 5; j++)
            vt.push_back(mk(1, 0, 1, 3, 1, 1, 0, 0, 1, 0, i2, 0));
        vt.push_back(mk(1, 0, 1, 3, 0, 1, 1, 1, 1, 0, fx, 0));
        vt.push_back(mk(1, 0, 1, 3, 0, 1, 0, 0, 1, 1, fx, 1));
        vt.push_back(mk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, fx, 1));
        // Counted start with cnt=0
        vt.push_back(mk(1, 0, 0, 3, 0, 1, 0, 0, 1, 1, fx, 0));
        vt.push_back(mk(0, 0, 0, 3, 0, 1, 0, 0, 0, 0, fx, 0));

        rst = 1'b1;
        patgen_en = 0; cntuspatt_en = 0; patgen_cnt = 0; patgen_sel = 0;
        chkr_fifo_full = 0; axist_tready = 0;
        #12;
        chk("rst_tvalid", axist_tvalid, 0);
        chk("rst_wr", patgen_din_wr, 0);
        chk("rst_busy", patgen_busy, 0);
        chk("rst_done", patgen_done, 0);
        chk("rst_din", patgen_din, 0);
        chk("rst_tdata", axist_tdata, 0);
        chk("rst_wcnt", patgen_word_cnt, 0);
        @(negedge wrclk) rst = 1'b0;
        @(negedge wrclk);

        foreach (vt[i]) begin
            patgen_en = vt[i].en; cntuspatt_en = vt[i].cen; patgen_cnt = vt[i].cnt;
            patgen_sel = vt[i].sel; chkr_fifo_full = vt[i].full; axist_tready = vt[i].rdy;
            @(negedge wrclk);
            chk($sformatf("v%0d_tvalid", i), axist_tvalid, vt[i].tv);
            chk($sformatf("v%0d_wr", i), patgen_din_wr, vt[i].wr);
            chk($sformatf("v%0d_busy", i), patgen_busy, vt[i].busy);
            chk($sformatf("v%0d_done", i), patgen_done, vt[i].done);
            chk($sformatf("v%0d_din", i), patgen_din, vt[i].din);
            chk($sformatf("v%0d_wcnt", i), patgen_word_cnt, vt[i].wcnt);
            chk($sformatf("v%0d_tdata", i), axist_tdata, bexp(vt[i].din));
        end

        // Continuous walking-one; both start edges together, continuous wins.
        patgen_en = 1; cntuspatt_en = 1; patgen_cnt = 1; patgen_sel = 2;
        chkr_fifo_full = 0; axist_tready = 1;
        pushes = 0; bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge wrclk);
            wexp = one80 << (i % 80);
            if (patgen_din_wr) pushes++;
            if (!axist_tvalid || patgen_din !== wexp || patgen_word_cnt !== 9'(i)) begin
                if (bad < 4)
                    $display("note beat %0d din=%0h wcnt=%0d tv=%0b", i, patgen_din, patgen_word_cnt, axist_tvalid);
                bad++;
            end
            if (i == 80) chk("walk_w80", patgen_din, one80);
        end
        chk("walk_bad_beats", bad, 0);
        chk("walk_pushes", pushes, 600);
        cntuspatt_en = 0; patgen_en = 0;
        @(negedge wrclk);
        chk("cont_end_done", patgen_done, 1);
        chk("cont_end_tvalid", axist_tvalid, 0);
        chk("cont_end_wr", patgen_din_wr, 0);
        chk("cont_end_wcnt", patgen_word_cnt, 88);
        chk("cont_end_din", patgen_din, one80 << 39);
        @(negedge wrclk);
        chk("cont_idle_busy", patgen_busy, 0);
        chk("cont_idle_done", patgen_done, 0);

        // Reset in the middle of a stalled beat, then restart from w[0].
        patgen_en = 1; patgen_cnt = 5; patgen_sel = 0; axist_tready = 1;
        @(negedge wrclk);
        chk("rr_w0", patgen_din, l0);
        @(negedge wrclk);
        chk("rr_w1", patgen_din, l1);
        axist_tready = 0;
        @(negedge wrclk);
        chk("rr_stall_tv", axist_tvalid, 1);
        #2 rst = 1'b1; patgen_en = 0;
        #1;
        chk("rr_async_tvalid", axist_tvalid, 0);
        chk("rr_async_wr", patgen_din_wr, 0);
        chk("rr_async_busy", patgen_busy, 0);
        chk("rr_async_din", patgen_din, 0);
        chk("rr_async_tdata", axist_tdata, 0);
        chk("rr_async_wcnt", patgen_word_cnt, 0);
        @(negedge wrclk) rst = 1'b0;
        @(negedge wrclk);
        patgen_en = 1; patgen_cnt = 1; axist_tready = 1;
        @(negedge wrclk);
        chk("rr_restart_din", patgen_din, l0);
        chk("rr_restart_wr", patgen_din_wr, 1);
        chk("rr_restart_tv", axist_tvalid, 1);
        @(negedge wrclk);
        chk("rr_restart_done", patgen_done, 1);
        chk("rr_restart_wcnt", patgen_word_cnt, 1);
        patgen_en = 0;
        @(negedge wrclk);
        chk("rr_final_busy", patgen_busy, 0);

        chk("push_has_beat", inv_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_st_patgen_h2f_top.md
# axi_st_patgen_h2f_top

AXI-ST pattern generator for the dual half2full loopback test path. It produces a programmable sequence of 80-bit seed words and pushes each one into the pattern checker's expected-data FIFO. It drives the same word, expanded to 512 bits, as an AXI-ST master beat toward the link. The checker downstream compares the expected data against the received data.

## Interface
- PATGEN_MODE, 1: width multiplier; seed word is PATGEN_MODE*80 bits (only 1 supported).
- AXIST_NUM_CHNL, 7: channel count used by the 512-bit expansion.
- LFSR_SEED, 40'h00_0000_0001: LFSR start value; zero is forced to 1.
- wrclk  in  1  sole clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- patgen_en  in  1  level; rising edge starts a counted run.
- cntuspatt_en  in  1  level; rising edge starts a continuous run, falling edge ends it.
- patgen_cnt  in  9  number of words in a counted run; latched at start.
- patgen_sel  in  2  pattern: 00 LFSR, 01 increment, 10 walking-one, 11 fixed.
- chkr_fifo_full  in  1  checker expected-FIFO full.
- patgen_din  out  80  expected seed word.
- patgen_din_wr  out  1  one-cycle push per word.
- axist_tvalid  out  1  AXI-ST valid.
- axist_tdata  out  512  expanded word.
- axist_tready  in  1  AXI-ST ready.
- patgen_busy  out  1  high in any state except IDLE.
- patgen_done  out  1  one-cycle run-complete pulse.
- patgen_word_cnt  out  9  accepted beats this run; wraps mod 512.

## Operation
- States:
  - IDLE: waits for a start edge.
  - WAIT: waiting because the checker FIFO is full.
  - SEND: axist_tvalid high.
  - DONE: one cycle.
- Start edges are detected from registered copies of patgen_en and cntuspatt_en. Starts arriving while busy are ignored. If both edges arrive in the same cycle, continuous mode wins.
- On start:
  - clear patgen_word_cnt and reload the LFSR and index k=0;
  - latch patgen_cnt;
  - a counted run with patgen_cnt==0 goes straight to DONE, with no push and no beat.
- Load rule, applied in IDLE on start, in WAIT, and in SEND on acceptance with words remaining:
  - if chkr_fifo_full is low, register patgen_din=w[k], pulse patgen_din_wr, and register axist_tdata=expand(w[k]) with axist_tvalid=1, in the same cycle;
  - otherwise go to WAIT with axist_tvalid=0.
- SEND holds tdata and tvalid stable until tready is high (AXI rule: no withdrawal of valid).
- Acceptance increments patgen_word_cnt. Then:
  - in a counted run, the last acceptance goes to DONE;
  - in a continuous run, loading repeats until cntuspatt_en is seen low, after which the current beat completes and the block goes to DONE; no new word is loaded after that.
- Patterns for word w[k], written as {hi40, lo40}:
  - LFSR: lo = state, hi = ~state; the state is a 40-bit Fibonacci LFSR with taps 40,38,21,19, stepped once per load.
  - Increment: lo = k, hi = ~k (k zero-extended to 40 bits).
  - Walking-one: 80'b1 << (k mod 80).
  - Fixed: {5{16'hAA55}}.
- Expansion:
  - tdata[40i+39:40i] = w[39:0] for i = 0..AXIST_NUM_CHNL-2;
  - tdata[255:240] = w[15:0];
  - tdata[256+40i+39:256+40i] = w[79:40];
  - tdata[511:496] = w[55:40].
- Reset, including mid-run: all outputs zero, state IDLE, LFSR = seed, immediately and without waiting for a clock edge.

## Timing
- Start edge sampled at edge E0: first push and tvalid are high in the cycle after E0 if the FIFO is not full.
- Full throughput is 1 word/cycle when tready=1 and chkr_fifo_full=0.
- patgen_din_wr count always equals the number of beats presented; a push never occurs without its beat.
- patgen_done is high for exactly the one cycle after the final acceptance edge. patgen_busy drops with it.
- chkr_fifo_full is sampled only at load points; it never stalls a beat already presented.

## Structure
- Package axi_st_patgen_pkg holds:
  - the state enum;
  - pattern select codes;
  - LFSR width and tap constants;
  - the fixed word 80'hAA55_AA55_AA55_AA55_AA55.
- Sub-module axi_st_patgen_word is the pattern-word generator: it takes sel, load, and restart, and outputs w[k] and k.
- The top module holds the FSM, counters, and expansion.

## Test plan
- LFSR, cnt=4, tready=1: 4 consecutive beats and 4 pushes. w[0] = {40'hFF_FFFF_FFFE, 40'h00_0000_0001}. Done is high one cycle after beat 4; word_cnt=4.
- Increment, cnt=3, tready low 3 cycles during beat 1: tdata/tvalid stable through the stall. Exactly 3 pushes. w[1].lo=1.
- chkr_fifo_full high for 5 cycles at start: no tvalid and no push for 5 cycles, then w[0] in the cycle after full drops.
- cnt=0 counted start: done pulse, zero beats, word_cnt=0.
- Continuous, walking-one, 600 beats, then cntuspatt_en low: w[80]=80'b1. word_cnt wraps to 88. Last beat completes, then done.
- rst asserted during SEND: tvalid, patgen_din_wr, and busy go to 0 asynchronously. The next start restarts from w[0].
